// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic array edge logic.
//   DATA_W          : default element width
//   feeder_state_t  : skew feeder FSM states
//   lane_get/put    : access lane idx of a flat lane-packed vector
//                     (lane i occupies bits [i*DATA_W +: DATA_W])
package systolic_pkg;

  localparam int DATA_W = 8;
  localparam int MAX_N  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } feeder_state_t;

  function automatic logic [DATA_W-1:0] lane_get(
    input logic [MAX_N*DATA_W-1:0] vec,
    input int unsigned             idx
  );
    return vec[idx*DATA_W +: DATA_W];
  endfunction

  function automatic logic [MAX_N*DATA_W-1:0] lane_put(
    input logic [MAX_N*DATA_W-1:0] vec,
    input int unsigned             idx,
    input logic [DATA_W-1:0]       val
  );
    logic [MAX_N*DATA_W-1:0] r;
    r = vec;
    r[idx*DATA_W +: DATA_W] = val;
    return r;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth delay line carrying a data word plus a valid bit.
//   clk_i, rst_i : clock, synchronous active-high clear
//   d_i, vld_i   : input word / valid
//   d_o, vld_o   : word / valid delayed by DEPTH cycles
module skew_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             vld_i,
  output logic [WIDTH-1:0] d_o,
  output logic             vld_o
);

  logic [DEPTH-1:0][WIDTH-1:0] dat_q;
  logic [DEPTH-1:0]            vld_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dat_q <= '0;
      vld_q <= '0;
    end else begin
      dat_q[0] <= d_i;
      vld_q[0] <= vld_i;
      for (int k = 1; k < DEPTH; k++) begin
        dat_q[k] <= dat_q[k-1];
        vld_q[k] <= vld_q[k-1];
      end
    end
  end

  assign d_o   = dat_q[DEPTH-1];
  assign vld_o = vld_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// West/north edge feeder of the systolic PE array: accepts one activation
// and one weight vector per cycle, delays lane i by i extra cycles, injects
// zero bubbles when no vector arrives, drains the skew and pulses done.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   start_i, k_len_i      : tile start pulse and vector count (IDLE only)
//   in_valid_i/in_ready_o : vector handshake
//   a_vec_i, b_vec_i      : lane-packed activation / weight vectors
//   row_data_o/col_data_o : skewed lanes to array rows / columns
//   lane_valid_o          : per-lane element-valid
//   busy_o, done_o        : FEED|FLUSH indicator, end-of-tile pulse
module systolic_skew_feeder #(
  parameter int N      = 4,
  parameter int DATA_W = 8,
  parameter int K_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [K_W-1:0]    k_len_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [N*DATA_W-1:0] a_vec_i,
  input  logic [N*DATA_W-1:0] b_vec_i,
  output logic [N*DATA_W-1:0] row_data_o,
  output logic [N*DATA_W-1:0] col_data_o,
  output logic [N-1:0]      lane_valid_o,
  output logic              busy_o,
  output logic              done_o
);
  import systolic_pkg::*;

  feeder_state_t  state_q, state_d;
  logic [K_W-1:0] k_len_q, k_len_d;
  logic [K_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [K_W-1:0] flush_cnt_q, flush_cnt_d;

  logic                accept;
  logic [N*DATA_W-1:0] a_in, b_in;

  // Non-accepted cycles push zeros so both MAC operands are zero and the
  // diagonal alignment of later vectors is kept.
  assign accept = (state_q == FEED) && in_valid_i;
  assign a_in   = accept ? a_vec_i : '0;
  assign b_in   = accept ? b_vec_i : '0;

  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    acc_cnt_d   = acc_cnt_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          k_len_d = k_len_i;
          state_d = (k_len_i == '0) ? DONE : FEED;
        end
      end
      FEED: begin
        if (accept) begin
          acc_cnt_d = acc_cnt_q + K_W'(1);
          if (acc_cnt_q + K_W'(1) == k_len_q) state_d = FLUSH;
        end
      end
      FLUSH: begin
        // N-1 drain cycles: lane N-1 shows the last element in the DONE cycle
        if (flush_cnt_q == K_W'(N-2)) state_d = DONE;
        else                          flush_cnt_d = flush_cnt_q + K_W'(1);
      end
      DONE: begin
        acc_cnt_d   = '0;
        flush_cnt_d = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      k_len_q     <= '0;
      acc_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      acc_cnt_q   <= acc_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Status decoded straight from the state register: glitch-free, no
  // combinational path from in_valid_i.
  assign in_ready_o = (state_q == FEED);
  assign busy_o     = (state_q == FEED) || (state_q == FLUSH);
  assign done_o     = (state_q == DONE);

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic a_vld, b_vld;

    skew_delay_line #(.DEPTH(i+1), .WIDTH(DATA_W)) u_a (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (a_in[i*DATA_W +: DATA_W]),
      .vld_i (accept),
      .d_o   (row_data_o[i*DATA_W +: DATA_W]),
      .vld_o (a_vld)
    );

    skew_delay_line #(.DEPTH(i+1), .WIDTH(DATA_W)) u_b (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .d_i   (b_in[i*DATA_W +: DATA_W]),
      .vld_i (accept),
      .d_o   (col_data_o[i*DATA_W +: DATA_W]),
      .vld_o (b_vld)
    );

    // Both streams share timing; combining keeps both valid chains live.
    assign lane_valid_o[i] = a_vld & b_vld;
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
module tb_systolic_skew_feeder;

  localparam int N      = 4;
  localparam int DATA_W = 8;
  localparam int K_W    = 16;

  localparam logic [31:0] Z  = 32'h0;
  localparam logic [31:0] A0 = 32'h04030201, B0 = 32'h68676665;
  localparam logic [31:0] A1 = 32'h08070605, B1 = 32'h6c6b6a69;
  localparam logic [31:0] A2 = 32'h0c0b0a09, B2 = 32'h706f6e6d;

  logic                clk = 1'b0;
  logic                rst, start, in_valid;
  logic [K_W-1:0]      k_len;
  logic [N*DATA_W-1:0] a_vec, b_vec;
  logic                in_ready, busy, done;
  logic [N*DATA_W-1:0] row_data, col_data;
  logic [N-1:0]        lane_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          v;
    logic [31:0] a;
    logic [31:0] b;
  } ent_t;
  ent_t hist[$];

  always #5 clk = ~clk;

  systolic_skew_feeder #(.N(N), .DATA_W(DATA_W), .K_W(K_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .k_len_i      (k_len),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .a_vec_i      (a_vec),
    .b_vec_i      (b_vec),
    .row_data_o   (row_data),
    .col_data_o   (col_data),
    .lane_valid_o (lane_valid),
    .busy_o       (busy),
    .done_o       (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Lane i must show what entered stage 0 i edges ago (skew reference).
  task automatic chk_lanes(input string tag);
    logic [31:0] er, ec, ev;
    int idx;
    er = '0; ec = '0; ev = '0;
    for (int i = 0; i < N; i++) begin
      idx = hist.size() - 1 - i;
      if (idx >= 0 && hist[idx].v) begin
        er[i*DATA_W +: DATA_W] = hist[idx].a[i*DATA_W +: DATA_W];
        ec[i*DATA_W +: DATA_W] = hist[idx].b[i*DATA_W +: DATA_W];
        ev[i] = 1'b1;
      end
    end
    chk({tag, " row"}, row_data, er);
    chk({tag, " col"}, col_data, ec);
    chk({tag, " lv"},  32'(lane_valid), ev);
  endtask

  // Drive one cycle, clock it, then check state seen after the edge.
  task automatic step(input int st, input int kl, input int v,
                      input logic [31:0] a, input logic [31:0] b, input int acc,
                      input int e_busy, input int e_rdy, input int e_done,
                      input string tag);
    ent_t e;
    start = (st != 0); k_len = 16'(kl); in_valid = (v != 0);
    a_vec = a; b_vec = b;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    e.v = (acc != 0);
    e.a = (acc != 0) ? a : Z;
    e.b = (acc != 0) ? b : Z;
    hist.push_back(e);
    chk_lanes(tag);
    chk({tag, " busy"},  32'(busy),     32'(e_busy));
    chk({tag, " rdy"},   32'(in_ready), 32'(e_rdy));
    chk({tag, " done"},  32'(done),     32'(e_done));
  endtask

  task automatic do_rst(input int v, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    rst = 1'b1; start = 1'b0; in_valid = (v != 0); a_vec = a; b_vec = b;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    hist.delete();
    chk_lanes(tag);
    chk({tag, " busy"}, 32'(busy),     32'h0);
    chk({tag, " rdy"},  32'(in_ready), 32'h0);
    chk({tag, " done"}, 32'(done),     32'h0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; in_valid = 1'b0; k_len = '0; a_vec = '0; b_vec = '0;

    do_rst(0, Z, Z, "reset");
    repeat (5) step(0, 0, 0, Z, Z, 0, 0, 0, 0, "idle");

    // Tile 1: k_len=3, continuous valid
    step(1, 3, 0, Z, Z, 0, 1, 1, 0, "t1 start");
    step(0, 0, 1, A0, B0, 1, 1, 1, 0, "t1 v0");
    chk("t1 lane0 first a", 32'(row_data[7:0]), 32'd1);
    chk("t1 lane0 first b", 32'(col_data[7:0]), 32'd101);
    step(0, 0, 1, A1, B1, 1, 1, 1, 0, "t1 v1");
    step(0, 0, 1, A2, B2, 1, 1, 0, 0, "t1 v2");
    step(0, 0, 0, Z, Z, 0, 1, 0, 0, "t1 flush1");
    chk("t1 lane3 first a", 32'(row_data[31:24]), 32'd4);
    step(0, 0, 0, Z, Z, 0, 1, 0, 0, "t1 flush2");
    step(0, 0, 0, Z, Z, 0, 0, 0, 1, "t1 done");
    chk("t1 lane3 last a", 32'(row_data[31:24]), 32'd12);
    chk("t1 lane3 last b", 32'(col_data[31:24]), 32'd112);
    chk("t1 lv at done",   32'(lane_valid),      32'h8);
    step(0, 0, 0, Z, Z, 0, 0, 0, 0, "t1 idle");

    // Tile 2: two bubbles after first vector
    step(1, 3, 0, Z, Z, 0, 1, 1, 0, "t2 start");
    step(0, 0, 1, A0, B0, 1, 1, 1, 0, "t2 v0");
    step(0, 0, 0, Z, Z, 0, 1, 1, 0, "t2 bub1");
    chk("t2 lane0 bubble lv", 32'(lane_valid[0]), 32'h0);
    step(0, 0, 0, Z, Z, 0, 1, 1, 0, "t2 bub2");
    step(0, 0, 1, A1, B1, 1, 1, 1, 0, "t2 v1");
    step(0, 0, 1, A2, B2, 1, 1, 0, 0, "t2 v2");
    step(0, 0, 0, Z, Z, 0, 1, 0, 0, "t2 flush1");
    step(0, 0, 0, Z, Z, 0, 1, 0, 0, "t2 flush2");
    step(0, 0, 0, Z, Z, 0, 0, 0, 1, "t2 done");
    chk("t2 lane3 last a", 32'(row_data[31:24]), 32'd12);
    step(0, 0, 0, Z, Z, 0, 0, 0, 0, "t2 idle");

    // k_len = 0
    step(1, 0, 0, Z, Z, 0, 0, 0, 1, "k0 done");
    step(0, 0, 0, Z, Z, 0, 0, 0, 0, "k0 idle");

    // start / in_valid during FLUSH are ignored
    step(1, 2, 0, Z, Z, 0, 1, 1, 0, "t3 start");
    step(0, 0, 1, A0, B0, 1, 1, 1, 0, "t3 v0");
    step(0, 0, 1, A1, B1, 1, 1, 0, 0, "t3 v1");
    step(1, 7, 1, A2, B2, 0, 1, 0, 0, "t3 flush start");
    step(0, 0, 1, A2, B2, 0, 1, 0, 0, "t3 flush vld");
    step(0, 0, 0, Z, Z, 0, 0, 0, 1, "t3 done");
    step(0, 0, 0, Z, Z, 0, 0, 0, 0, "t3 idle");
    step(1, 1, 0, Z, Z, 0, 1, 1, 0, "t4 start");
    step(0, 0, 1, A2, B2, 1, 1, 0, 0, "t4 v0");
    step(0, 0, 0, Z, Z, 0, 1, 0, 0, "t4 flush1");
    step(0, 0, 0, Z, Z, 0, 1, 0, 0, "t4 flush2");
    step(0, 0, 0, Z, Z, 0, 0, 0, 1, "t4 done");
    chk("t4 lane3 a", 32'(row_data[31:24]), 32'd12);
    step(0, 0, 0, Z, Z, 0, 0, 0, 0, "t4 idle");

    // Reset mid-FEED after 2 of 5 accepts
    step(1, 5, 0, Z, Z, 0, 1, 1, 0, "t5 start");
    step(0, 0, 1, A0, B0, 1, 1, 1, 0, "t5 v0");
    step(0, 0, 1, A1, B1, 1, 1, 1, 0, "t5 v1");
    do_rst(1, A2, B2, "t5 rst");
    step(0, 0, 0, Z, Z, 0, 0, 0, 0, "t5 post1");
    step(0, 0, 0, Z, Z, 0, 0, 0, 0, "t5 post2");

    // Fresh tile after reset
    step(1, 2, 0, Z, Z, 0, 1, 1, 0, "t6 start");
    step(0, 0, 1, A2, B2, 1, 1, 1, 0, "t6 v0");
    step(0, 0, 1, A0, B0, 1, 1, 0, 0, "t6 v1");
    step(0, 0, 0, Z, Z, 0, 1, 0, 0, "t6 flush1");
    step(0, 0, 0, Z, Z, 0, 1, 0, 0, "t6 flush2");
    step(0, 0, 0, Z, Z, 0, 0, 0, 1, "t6 done");
    chk("t6 lane3 last a", 32'(row_data[31:24]), 32'd4);
    step(0, 0, 0, Z, Z, 0, 0, 0, 0, "t6 idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
